// File: rtl/block_pkg.sv
// Shared types and defaults for the block assembler: hash width, FSM states, fold helper.
package block_pkg;

  localparam int HASH_W         = 128;
  localparam int BLOCK_SIZE_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF    = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Digest fold: rotate the running digest left by one, then xor in the new hash.
  function automatic logic [HASH_W-1:0] fold(input logic [HASH_W-1:0] digest,
                                             input logic [HASH_W-1:0] hash);
    return {digest[HASH_W-2:0], digest[HASH_W-1]} ^ hash;
  endfunction

endpackage

// File: rtl/hash_fifo.sv
// Synchronous FIFO, one cycle from push to visible at the head.
// Accepts a push while full only when a pop happens in the same cycle.
module hash_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/block_assembler.sv
// Folds validated hashes into block summaries; i_valid->o_valid is 2 cycles when a hash completes a block.
// No backpressure upstream: hashes arriving on a full FIFO are dropped and counted; summary waits on i_ready.
module block_assembler
  import block_pkg::*;
#(
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [HASH_W-1:0] i_hash,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [HASH_W-1:0] o_digest,
  output logic [7:0]        o_count,
  output logic [15:0]       o_seq,
  output logic              o_overflow,
  output logic [7:0]        o_drop_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [HASH_W-1:0] fifo_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic [TW-1:0]     idle_cnt;

  assign pop  = !fifo_empty && (state != EMIT);
  assign push = i_valid && (!fifo_full || pop);
  assign drop = i_valid && fifo_full && !pop;

  hash_fifo #(
    .WIDTH (HASH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (i_hash),
    .pop   (pop),
    .dout  (fifo_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // o_digest/o_count are the live accumulators; they freeze in EMIT because nothing pops there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idle_cnt   <= '0;
      o_valid    <= 1'b0;
      o_digest   <= '0;
      o_count    <= '0;
      o_seq      <= '0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      end
      case (state)
        IDLE, ACCUM: begin
          if (pop) begin
            o_digest <= fold(o_digest, fifo_dat);
            o_count  <= o_count + 8'd1;
            idle_cnt <= '0;
            if (o_count == 8'(BLOCK_SIZE - 1)) begin
              state   <= EMIT;
              o_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end else if (state == ACCUM) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
              state    <= EMIT;
              o_valid  <= 1'b1;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end
        EMIT: begin
          if (i_ready) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_digest <= '0;
            o_count  <= '0;
            o_seq    <= o_seq + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
